// File: rtl/rc5_tx_scheduler.sv
// RC-5 transmit scheduler: arbitrates two key requesters, builds the 14-bit
// frame, launches it into the Manchester serializer and paces auto-repeats.
module rc5_tx_scheduler #(
    parameter int BIT_CLKS    = 100,
    parameter int REPEAT_BITS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [10:0] code0,
    input  logic        req1,
    input  logic [10:0] code1,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [13:0] frame,
    output logic [1:0]  grant,
    output logic        toggle,
    output logic        active
);

    localparam int DW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int BW = $clog2(REPEAT_BITS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CLKS - 1);
    localparam logic [BW-1:0] BITS_SAT = BW'(REPEAT_BITS);
    localparam logic [BW-1:0] BITS_PRE = BW'(REPEAT_BITS - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

    state_t        state_q, state_d;
    logic          toggle_q, toggle_d;
    logic          ptr_q, ptr_d;
    logic [1:0]    grant_q, grant_d;
    logic [10:0]   code_q, code_d;
    logic [13:0]   frame_q, frame_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bits_q, bits_d;
    logic          first_q, first_d;

    logic [DW-1:0] div_base;
    logic [BW-1:0] bits_base;
    logic          expire;
    logic          pick1;
    logic          own_req;
    logic [10:0]   own_code;

    // Bit-period timing. The LAUNCH cycle is the first divider tick, so the
    // next launch lands exactly REPEAT_BITS*BIT_CLKS cycles after this one.
    always_comb begin
        div_base  = (state_q == LAUNCH) ? '0 : div_q;
        bits_base = (state_q == LAUNCH) ? '0 : bits_q;
        div_d     = div_base + 1'b1;
        bits_d    = bits_base;
        if (div_base == DIV_LAST) begin
            div_d  = '0;
            bits_d = (bits_base == BITS_SAT) ? bits_base : bits_base + 1'b1;
        end
        if (state_q == IDLE) begin
            div_d  = '0;
            bits_d = '0;
        end
    end

    // Repeat period is over once the count saturates or is about to.
    assign expire = (bits_q == BITS_SAT) ||
                    ((bits_q == BITS_PRE) && (div_q == DIV_LAST));

    assign pick1    = req1 & (~req0 | ptr_q);
    assign own_req  = grant_q[0] ? req0  : (grant_q[1] & req1);
    assign own_code = grant_q[0] ? code0 : code1;

    // Next-state logic: arbitration, code latch, toggle ownership, pacing.
    always_comb begin
        state_d  = state_q;
        toggle_d = toggle_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        code_d   = code_q;
        frame_d  = frame_q;
        first_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    if (req0 & req1) ptr_d = ~pick1;
                    grant_d  = pick1 ? 2'b10 : 2'b01;
                    code_d   = pick1 ? code1 : code0;
                    toggle_d = ~toggle_q;
                    frame_d  = {2'b11, ~toggle_q, pick1 ? code1 : code0};
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                first_d = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // busy is not yet valid in the first cycle after the launch
                if (!first_q && !tx_busy) state_d = GAP;
            end
            GAP: begin
                if (expire) begin
                    if (own_req) begin
                        if (own_code != code_q) begin
                            code_d   = own_code;
                            toggle_d = ~toggle_q;
                            frame_d  = {2'b11, ~toggle_q, own_code};
                        end
                        state_d = LAUNCH;
                    end else begin
                        grant_d = 2'b00;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            toggle_q <= 1'b0;
            ptr_q    <= 1'b0;
            grant_q  <= 2'b00;
            code_q   <= '0;
            frame_q  <= '0;
            div_q    <= '0;
            bits_q   <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            toggle_q <= toggle_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            code_q   <= code_d;
            frame_q  <= frame_d;
            div_q    <= div_d;
            bits_q   <= bits_d;
            first_q  <= first_d;
        end
    end

    assign tx_start = (state_q == LAUNCH);
    assign frame    = frame_q;
    assign grant    = grant_q;
    assign toggle   = toggle_q;
    assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_rc5_tx_scheduler.sv
// Bench for rc5_tx_scheduler: serializer model, launch scoreboard, a press
// table and hand sequences for arbitration, code change, long busy, reset.
module tb_rc5_tx_scheduler;

    localparam int BC = 4;
    localparam int RB = 64;
    localparam int PER = BC * RB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [10:0] code0 = '0, code1 = '0;
    logic        tx_busy;
    logic        tx_start;
    logic [13:0] frame;
    logic [1:0]  grant;
    logic        toggle;
    logic        active;

    rc5_tx_scheduler #(.BIT_CLKS(BC), .REPEAT_BITS(RB)) dut (
        .clk(clk), .rst(rst), .req0(req0), .code0(code0), .req1(req1),
        .code1(code1), .tx_busy(tx_busy), .tx_start(tx_start), .frame(frame),
        .grant(grant), .toggle(toggle), .active(active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serializer model: busy for busy_len cycles starting the cycle after tx_start.
    int busy_len = 56;
    int bcnt = 0;
    always @(posedge clk) begin
        if (tx_start) bcnt <= busy_len;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt > 0);

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [13:0] frame;
        logic [1:0]  grant;
        logic        tog;
        int          at;
    } exp_t;
    exp_t sb[$];

    task automatic push(input logic [10:0] code, input logic [1:0] g, input logic t, input int at);
        exp_t e;
        e.frame = {2'b11, t, code};
        e.grant = g;
        e.tog   = t;
        e.at    = at;
        sb.push_back(e);
    endtask

    // Every launch must match the next expected launch in order and timing.
    exp_t got;
    always @(negedge clk) begin
        if (tx_start) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_launch: frame %0h at cycle %0d, none expected", frame, cyc);
            end else begin
                got = sb.pop_front();
                chk("launch_cycle", cyc, got.at);
                chk("launch_frame", {18'd0, frame}, {18'd0, got.frame});
                chk("launch_grant", {30'd0, grant}, {30'd0, got.grant});
                chk("launch_toggle", {31'd0, toggle}, {31'd0, got.tog});
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        chk("reset_tx_start", {31'd0, tx_start}, 0);
        chk("reset_frame", {18'd0, frame}, 0);
        chk("reset_grant", {30'd0, grant}, 0);
        chk("reset_toggle", {31'd0, toggle}, 0);
        chk("reset_active", {31'd0, active}, 0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          which;
        logic [10:0] code;
        int          n;
        logic [1:0]  exp_grant;
        logic        exp_tog;
    } press_t;
    press_t tbl[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        tbl[0] = '{1'b0, 11'h0C5, 3, 2'b01, 1'b1};
        tbl[1] = '{1'b0, 11'h0C5, 1, 2'b01, 1'b0};
        tbl[2] = '{1'b0, 11'h0C5, 1, 2'b01, 1'b1};
        tbl[3] = '{1'b1, 11'h2AA, 2, 2'b10, 1'b0};
        tbl[4] = '{1'b0, 11'h7FF, 1, 2'b01, 1'b1};
        tbl[5] = '{1'b1, 11'h000, 1, 2'b10, 1'b0};

        do_reset();

        // Single-requester presses: launch, repeats, release to idle.
        for (int i = 0; i < 6; i++) begin
            c = cyc;
            if (!tbl[i].which) begin req0 = 1'b1; code0 = tbl[i].code; end
            else               begin req1 = 1'b1; code1 = tbl[i].code; end
            for (int k = 0; k < tbl[i].n; k++)
                push(tbl[i].code, tbl[i].exp_grant, tbl[i].exp_tog, c + 1 + PER * k);
            wait_cyc(c + 1 + PER * (tbl[i].n - 1) + 20);
            chk("press_active", {31'd0, active}, 1);
            chk("press_grant", {30'd0, grant}, {30'd0, tbl[i].exp_grant});
            req0 = 1'b0;
            req1 = 1'b0;
            wait_cyc(c + PER * tbl[i].n + 2);
            chk("release_active", {31'd0, active}, 0);
            chk("release_grant", {30'd0, grant}, 0);
            chk("release_toggle", {31'd0, toggle}, {31'd0, tbl[i].exp_tog});
        end

        // One-cycle tap still yields exactly one frame.
        c = cyc;
        req0 = 1'b1; code0 = 11'h155;
        push(11'h155, 2'b01, 1'b1, c + 1);
        step();
        req0 = 1'b0;
        wait_cyc(c + 300);
        chk("tap_idle", {31'd0, active}, 0);

        // Simultaneous requests: req0 first, req1 waits until release.
        do_reset();
        c = cyc;
        req0 = 1'b1; code0 = 11'h0C5;
        req1 = 1'b1; code1 = 11'h123;
        for (int k = 0; k < 3; k++) push(11'h0C5, 2'b01, 1'b1, c + 1 + PER * k);
        push(11'h123, 2'b10, 1'b0, c + 3 * PER + 2);
        wait_cyc(c + 2 * PER + 21);
        chk("both_owner", {30'd0, grant}, 2'b01);
        req0 = 1'b0;
        wait_cyc(c + 3 * PER + 22);
        req1 = 1'b0;
        wait_cyc(c + 4 * PER + 3);
        chk("both_idle", {31'd0, active}, 0);

        // Pointer now favours req1.
        c = cyc;
        req0 = 1'b1; req1 = 1'b1;
        push(11'h123, 2'b10, 1'b1, c + 1);
        wait_cyc(c + 20);
        req0 = 1'b0; req1 = 1'b0;
        wait_cyc(c + PER + 2);
        chk("rr_idle", {31'd0, active}, 0);

        // Code change while the frame is in flight.
        do_reset();
        c = cyc;
        req0 = 1'b1; code0 = 11'h0C5;
        push(11'h0C5, 2'b01, 1'b1, c + 1);
        push(11'h0C6, 2'b01, 1'b0, c + 1 + PER);
        wait_cyc(c + 10);
        code0 = 11'h0C6;
        wait_cyc(c + 20);
        chk("inflight_frame", {18'd0, frame}, {18'd0, 2'b11, 1'b1, 11'h0C5});
        wait_cyc(c + 1 + PER + 20);
        req0 = 1'b0;
        wait_cyc(c + 2 * PER + 2);
        chk("chg_idle", {31'd0, active}, 0);

        // Serializer busy past the repeat period.
        do_reset();
        busy_len = 300;
        c = cyc;
        req0 = 1'b1; code0 = 11'h0C5;
        push(11'h0C5, 2'b01, 1'b1, c + 1);
        push(11'h0C5, 2'b01, 1'b1, c + 304);
        wait_cyc(c + 280);
        chk("long_busy_active", {31'd0, active}, 1);
        wait_cyc(c + 324);
        req0 = 1'b0;
        wait_cyc(c + 304 + 304);
        chk("long_idle", {31'd0, active}, 0);
        busy_len = 56;

        // Reset in the middle of a frame.
        do_reset();
        c = cyc;
        req0 = 1'b1; code0 = 11'h0C5;
        push(11'h0C5, 2'b01, 1'b1, c + 1);
        wait_cyc(c + 30);
        rst = 1'b1;
        step();
        chk("midrst_tx_start", {31'd0, tx_start}, 0);
        chk("midrst_frame", {18'd0, frame}, 0);
        chk("midrst_grant", {30'd0, grant}, 0);
        chk("midrst_toggle", {31'd0, toggle}, 0);
        chk("midrst_active", {31'd0, active}, 0);
        rst = 1'b0;
        push(11'h0C5, 2'b01, 1'b1, c + 32);
        wait_cyc(c + 52);
        req0 = 1'b0;
        wait_cyc(c + 32 + PER + 1);
        chk("midrst_idle", {31'd0, active}, 0);

        wait_cyc(cyc + 5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rc5_tx_scheduler.md
Name: rc5_tx_scheduler

Overview:
Sequences the RC-5 Manchester transmit datapath. Arbitrates two key requesters (local keypad, host interface) for the single transmitter and builds the 14-bit frame {start1=1, start2=1, toggle, code[10:0]}. Launches frames into the serializer and enforces the RC-5 repeat period. Owns the toggle bit: it flips per new key press and is held across auto-repeats of the same press.

Parameters:
BIT_CLKS, 100, clk cycles per RC-5 bit period (half-bit Manchester timing belongs to the serializer)
REPEAT_BITS, 64, bit periods from one frame launch to the next launch (repeat interval)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req0  in  1  requester 0 key held (level)
code0  in  11  requester 0 {address[4:0], command[5:0]}
req1  in  1  requester 1 key held (level)
code1  in  11  requester 1 code
tx_busy  in  1  serializer busy; rises the cycle after tx_start, falls when the last half-bit has been sent
tx_start  out  1  one-cycle launch pulse to serializer
frame  out  14  {1,1,toggle,code}; stable from tx_start until tx_busy falls
grant  out  2  one-hot current owner, 00 when idle
toggle  out  1  current toggle bit
active  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, wins over all inputs, including mid-frame): state=IDLE, tx_start=0, frame=0, grant=00, toggle=0, active=0, round-robin pointer=0 (req0 preferred), all counters=0. A serializer left mid-frame is not waited for.
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE: if neither req is high, stay. If one req is high, grant it. If both are high, grant the requester the pointer favours, then move the pointer to the other requester. Latch the owner's code and flip toggle (new press). Go to LAUNCH the next cycle.
- LAUNCH (1 cycle): tx_start=1, frame={2'b11,toggle,latched_code}. Clear clock divider and bit counter. Go to WAIT_DONE.
- WAIT_DONE: exit to GAP on the first cycle with tx_busy=0, counted from the second cycle after LAUNCH. Divider and bit counter keep running.
- Bit timing: divider counts 0..BIT_CLKS-1. On wrap, bit counter increments and saturates at REPEAT_BITS. Period is measured launch-to-launch: REPEAT_BITS*BIT_CLKS cycles.
- GAP: wait until bit counter = REPEAT_BITS, then evaluate the owner:
  - Owner req high, code equal to latched code: LAUNCH again, toggle unchanged (repeat).
  - Owner req high, code changed: latch new code, flip toggle, LAUNCH (new press).
  - Owner req low: grant=00, go to IDLE. Arbitration then runs the next cycle, so the other requester waits at most one extra cycle.
- No preemption: the non-owner requester is ignored while the owner holds its key.
- If tx_busy is still high when the bit counter saturates, stay in WAIT_DONE. GAP evaluation happens the cycle after tx_busy falls, with no additional gap.
- Owner releasing during WAIT_DONE or GAP does not abort the frame in flight. Release is acted on only at the GAP decision.
- Short taps: a req pulse of a single cycle that is seen in IDLE still produces exactly one frame.
- A code change in WAIT_DONE does not alter frame. Frame is held constant until tx_busy falls.
- Toggle wraps 1→0→1 freely. It is shared by both requesters, so a new press from either flips it.

Test Plan:
BIT_CLKS=4, REPEAT_BITS=64 (period 256 cycles). Serializer model: busy for 56 cycles after each start.

1. Reset, then req0=1 held, code0=11'h0C5 -> tx_start at cycle 2 with frame=14'b11_1_00011000101, grant=01, toggle=1. Repeat tx_start every 256 cycles, toggle stays 1. Release req0 -> grant=00 and active=0 after the current GAP.
2. Second press of req0, same code -> toggle=0, frame[11]=0. Third press -> toggle=1.
3. req0 and req1 rise in the same cycle from reset -> grant=01 first. Hold req0 for 3 frames, req1 stays high throughout -> req1 gets no tx_start. After req0 drops, grant=10 and the first req1 frame launches at most 2 cycles after GAP expiry, toggle flipped.
4. Owner changes code0 from 0x0C5 to 0x0C6 during WAIT_DONE -> frame in flight unchanged. Next launch, 256 cycles later, carries 0x0C6 with toggle flipped.
5. Serializer model holds busy for 300 cycles -> next tx_start occurs exactly 2 cycles after busy falls (cycle 303 relative to the previous launch), not at 256.
6. rst asserted mid-WAIT_DONE -> next cycle tx_start=0, frame=0, grant=00, toggle=0. req0 still high -> new frame launches 2 cycles after rst deasserts, toggle=1.
